// File: rtl/cache_req_pkg.sv
// cache_req_pkg: shared types for the cache requester.
//   state_t : requester FSM states
//   op_t    : latched command kind (read/write)
//   STAT_W  : width of the optional statistics counters (CACHE_REQ_STATS_EN)
package cache_req_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        WR_WAIT,
        RESP
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    localparam int STAT_W = 16;

endpackage

// File: rtl/cache_req_stats.sv
// cache_req_stats: response statistics, present only when CACHE_REQ_STATS_EN
// is defined. Each counter advances on a response handshake and wraps.
//   clock, reset_n     : clock, asynchronous active-low reset
//   rsp_fire           : response handshake strobe
//   op, hit, timeout   : qualifiers of the response being handed over
//   stat_rd_hit        : reads that hit
//   stat_rd_miss       : reads that missed
//   stat_wr_ok         : writes committed
//   stat_wr_timeout    : writes aborted after MAX_WAIT
`ifdef CACHE_REQ_STATS_EN
module cache_req_stats
    import cache_req_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rsp_fire,
    input  op_t               op,
    input  logic              hit,
    input  logic              timeout,
    output logic [STAT_W-1:0] stat_rd_hit,
    output logic [STAT_W-1:0] stat_rd_miss,
    output logic [STAT_W-1:0] stat_wr_ok,
    output logic [STAT_W-1:0] stat_wr_timeout
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_rd_hit     <= '0;
            stat_rd_miss    <= '0;
            stat_wr_ok      <= '0;
            stat_wr_timeout <= '0;
        end else if (rsp_fire) begin
            if (op == OP_RD) begin
                if (hit) stat_rd_hit  <= stat_rd_hit + 1'b1;
                else     stat_rd_miss <= stat_rd_miss + 1'b1;
            end else begin
                if (hit)     stat_wr_ok      <= stat_wr_ok + 1'b1;
                if (timeout) stat_wr_timeout <= stat_wr_timeout + 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/cache_requester.sv
// cache_requester: single-outstanding initiator for the K-way CLOCK cache port.
// Accepts one command on the req channel, drives the registered cache strobes,
// waits for the cache's registered hit, then presents the result on rsp.
// Write misses keep cache_write asserted until hit (covers the eviction sweep)
// or until MAX_WAIT WR_WAIT cycles have elapsed (rsp_timeout).
// Ports:
//   clock, reset_n                        : clock, asynchronous active-low reset
//   req_valid/req_ready/req_write/req_addr/req_data : upstream command
//   rsp_valid/rsp_ready/rsp_hit/rsp_data/rsp_timeout : downstream response
//   cache_addr/cache_val/cache_read/cache_write     : registered cache drive
//   cache_hit/cache_out_val                         : cache response
//   stat_* (only with CACHE_REQ_STATS_EN)           : 16-bit response counters
module cache_requester
    import cache_req_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LINE_WIDTH = 32,
    parameter int MAX_WAIT   = 6
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LINE_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_hit,
    output logic [LINE_WIDTH-1:0] rsp_data,
    output logic                  rsp_timeout,
`ifdef CACHE_REQ_STATS_EN
    output logic [STAT_W-1:0]     stat_rd_hit,
    output logic [STAT_W-1:0]     stat_rd_miss,
    output logic [STAT_W-1:0]     stat_wr_ok,
    output logic [STAT_W-1:0]     stat_wr_timeout,
`endif
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [LINE_WIDTH-1:0] cache_val,
    output logic                  cache_read,
    output logic                  cache_write,
    input  logic                  cache_hit,
    input  logic [LINE_WIDTH-1:0] cache_out_val
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_WAIT);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_inc;

    // Saturating count including the current WR_WAIT cycle; the abort decision
    // uses it so exactly MAX_WAIT WR_WAIT cycles elapse before rsp_timeout.
    assign wait_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_hit     <= 1'b0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
            cache_addr  <= '0;
            cache_val   <= '0;
            cache_read  <= 1'b0;
            cache_write <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready   <= 1'b0;
                        cache_addr  <= req_addr;
                        cache_val   <= req_data;
                        rsp_hit     <= 1'b0;
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b0;
                        if (req_write) begin
                            cache_write <= 1'b1;
                            wait_cnt    <= '0;
                            state       <= WR_ISSUE;
                        end else begin
                            cache_read <= 1'b1;
                            state      <= RD_ISSUE;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                RD_ISSUE: begin
                    cache_read <= 1'b0;
                    state      <= RD_WAIT;
                end
                RD_WAIT: begin
                    rsp_hit   <= cache_hit;
                    rsp_data  <= cache_hit ? cache_out_val : '0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                WR_ISSUE: begin
                    state <= WR_WAIT;
                end
                WR_WAIT: begin
                    wait_cnt <= wait_inc;
                    if (cache_hit) begin
                        cache_write <= 1'b0;
                        rsp_hit     <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else if (wait_inc == CNT_LIMIT) begin
                        cache_write <= 1'b0;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_REQ_STATS_EN
    op_t op;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op <= OP_RD;
        end else if (state == IDLE && req_valid && req_ready) begin
            op <= req_write ? OP_WR : OP_RD;
        end
    end

    cache_req_stats u_stats (
        .clock           (clock),
        .reset_n         (reset_n),
        .rsp_fire        (rsp_valid && rsp_ready),
        .op              (op),
        .hit             (rsp_hit),
        .timeout         (rsp_timeout),
        .stat_rd_hit     (stat_rd_hit),
        .stat_rd_miss    (stat_rd_miss),
        .stat_wr_ok      (stat_wr_ok),
        .stat_wr_timeout (stat_wr_timeout)
    );
`endif

endmodule

// File: tb/tb_cache_requester.sv
// Bench for cache_requester paired with a behavioural 2-way CLOCK cache.
module tb_cache_requester;

    localparam int AW = 8;
    localparam int LW = 32;
    localparam int MW = 6;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic          rsp_hit;
    logic [LW-1:0] rsp_data;
    logic          rsp_timeout;
    logic [AW-1:0] cache_addr;
    logic [LW-1:0] cache_val;
    logic          cache_read;
    logic          cache_write;
    logic          cache_hit;
    logic [LW-1:0] cache_out_val;
`ifdef CACHE_REQ_STATS_EN
    logic [15:0]   stat_rd_hit, stat_rd_miss, stat_wr_ok, stat_wr_timeout;
`endif

    cache_requester #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .MAX_WAIT(MW)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_hit       (rsp_hit),
        .rsp_data      (rsp_data),
        .rsp_timeout   (rsp_timeout),
`ifdef CACHE_REQ_STATS_EN
        .stat_rd_hit     (stat_rd_hit),
        .stat_rd_miss    (stat_rd_miss),
        .stat_wr_ok      (stat_wr_ok),
        .stat_wr_timeout (stat_wr_timeout),
`endif
        .cache_addr    (cache_addr),
        .cache_val     (cache_val),
        .cache_read    (cache_read),
        .cache_write   (cache_write),
        .cache_hit     (cache_hit),
        .cache_out_val (cache_out_val)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- behavioural cache, K=2, CLOCK replacement -------------
    logic          stub = 1'b0;
    logic          c_vld  [2] = '{default: 1'b0};
    logic [AW-1:0] c_tag  [2] = '{default: '0};
    logic [LW-1:0] c_data [2] = '{default: '0};
    logic          c_ref  [2] = '{default: 1'b0};
    int            hand = 0;
    logic          env_hit = 1'b0;
    logic [LW-1:0] env_out = '0;
    int            env_m;

    always_comb begin
        env_m = -1;
        for (int i = 0; i < 2; i++)
            if (c_vld[i] && c_tag[i] == cache_addr) env_m = i;
    end

    always @(posedge clock) begin
        if (!stub && cache_write) begin
            env_out <= '0;
            if (env_m >= 0) begin
                c_data[env_m] <= cache_val;
                c_ref[env_m]  <= 1'b1;
                env_hit       <= 1'b1;
            end else if (!c_vld[hand] || !c_ref[hand]) begin
                c_vld[hand]  <= 1'b1;
                c_tag[hand]  <= cache_addr;
                c_data[hand] <= cache_val;
                c_ref[hand]  <= 1'b1;
                hand         <= (hand + 1) % 2;
                env_hit      <= 1'b1;
            end else begin
                c_ref[hand] <= 1'b0;
                hand        <= (hand + 1) % 2;
                env_hit     <= 1'b0;
            end
        end else if (!stub && cache_read) begin
            env_hit <= (env_m >= 0);
            env_out <= (env_m >= 0) ? c_data[env_m] : '0;
            if (env_m >= 0) c_ref[env_m] <= 1'b1;
        end else begin
            env_hit <= 1'b0;
            env_out <= '0;
        end
    end

    assign cache_hit     = stub ? 1'b0 : env_hit;
    assign cache_out_val = env_out;

    function automatic logic present(input logic [AW-1:0] a);
        for (int i = 0; i < 2; i++)
            if (c_vld[i] && c_tag[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic          hit;
        logic [LW-1:0] data;
        logic          tout;
        logic          is_rd;
        int unsigned   acc;
    } exp_t;

    exp_t          sb[$];
    logic [LW-1:0] ref_mem [logic [AW-1:0]];
    int            checks = 0;
    int            errors = 0;
    int            rdy_mode = 1;   // 0 random, 1 always ready, 2 stalled
    int            wr_hi = 0;
    logic          last_hit = 1'b0;
    logic [LW-1:0] last_data = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", nm, act, req, cyc);
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (rdy_mode)
                0:       rsp_ready = 1'($urandom_range(0, 1));
                1:       rsp_ready = 1'b1;
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // Monitor: protocol rules every cycle, pops expected on each response handshake.
    initial begin
        logic          pv, pr, ph, pt;
        logic [LW-1:0] pd;
        exp_t          e;
        pv = 0; pr = 0; ph = 0; pt = 0; pd = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                pv = 0;
                continue;
            end
            if (cache_write) wr_hi++;
            if (cache_read && cache_write) check("strobe_excl", {cache_read, cache_write}, 2'b00);
            if (rsp_valid) begin
                check("rsp_req_ready", req_ready, 0);
                check("rsp_strobes", {cache_read, cache_write}, 2'b00);
                if (!pv) begin
                    if (sb.size() > 0 && sb[0].is_rd) check("rd_latency", cyc - sb[0].acc, 3);
                end else if (!pr) begin
                    check("hold_hit", rsp_hit, ph);
                    check("hold_data", rsp_data, pd);
                    check("hold_timeout", rsp_timeout, pt);
                end
                if (rsp_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected actual=valid required=none at cycle %0d", cyc);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_hit", rsp_hit, e.hit);
                        check("rsp_data", rsp_data, e.data);
                        check("rsp_timeout", rsp_timeout, e.tout);
                    end
                    last_hit  = rsp_hit;
                    last_data = rsp_data;
                end
            end
            pv = rsp_valid; pr = rsp_ready; ph = rsp_hit; pd = rsp_data; pt = rsp_timeout;
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] d);
        exp_t e;
        int   n;
        @(negedge clock);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_data = d;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_accept actual=not_ready required=ready at cycle %0d", cyc);
            req_valid = 1'b0;
            return;
        end
        e.acc   = cyc;
        e.is_rd = !wr;
        if (stub && wr) begin
            e.hit = 1'b0; e.data = '0; e.tout = 1'b1;
        end else if (wr) begin
            e.hit = 1'b1; e.data = '0; e.tout = 1'b0;
            ref_mem[a] = d;
        end else begin
            e.hit  = present(a);
            e.data = (e.hit && ref_mem.exists(a)) ? ref_mem[a] : '0;
            e.tout = 1'b0;
        end
        sb.push_back(e);
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=%0d required=0 pending at cycle %0d", sb.size(), cyc);
            sb.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic h1, h2;
        int   n;
        // reset state
        repeat (3) @(negedge clock);
        check("reset_flags", {req_ready, rsp_valid, rsp_hit, rsp_timeout, cache_read, cache_write}, 0);
        check("reset_bus", {cache_addr, cache_val[23:0]}, 0);
        check("reset_rsp_data", rsp_data, 0);
        reset_n = 1'b1;
        #1 check("ready_at_release", req_ready, 0);
        @(negedge clock);
        check("ready_after_release", req_ready, 1);

        // read of empty cache
        issue(1'b0, 8'h10, 32'h0);
        wait_done();
        check("empty_read_hit", last_hit, 0);
        check("empty_read_data", last_data, 0);

        // write miss then read back
        issue(1'b1, 8'h10, 32'hDEADBEEF);
        wait_done();
        check("wr_commit", last_hit, 1);
        issue(1'b0, 8'h10, 32'h0);
        wait_done();
        check("rd_after_wr", last_data, 32'hDEADBEEF);

        // fill and evict
        issue(1'b1, 8'h20, 32'hCAFE0020);
        issue(1'b1, 8'h30, 32'hCAFE0030);
        wait_done();
        check("evict_commit", last_hit, 1);
        issue(1'b0, 8'h10, 32'h0);
        wait_done();
        h1 = last_hit;
        issue(1'b0, 8'h20, 32'h0);
        wait_done();
        h2 = last_hit;
        check("evict_one_miss", 32'(h1) + 32'(h2), 1);
        issue(1'b0, 8'h30, 32'h0);
        wait_done();
        check("evict_new_line", last_data, 32'hCAFE0030);

        // stalled response
        rdy_mode = 2;
        issue(1'b0, 8'h30, 32'h0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("stall_valid", rsp_valid, 1);
        repeat (5) @(negedge clock);
        check("stall_still_valid", rsp_valid, 1);
        rdy_mode = 1;
        wait_done();

        // cache never hits: write must time out after MAX_WAIT WR_WAIT cycles
        stub = 1'b1;
        wr_hi = 0;
        issue(1'b1, 8'h60, 32'h12345678);
        wait_done();
        check("timeout_write_cycles", wr_hi, 1 + MW);
        check("timeout_write_low", cache_write, 0);
        check("timeout_flag", last_hit, 0);

        // reset during WR_WAIT
        issue(1'b1, 8'h50, 32'h11110050);
        @(negedge clock);
        @(negedge clock);
        check("wr_wait_write", cache_write, 1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_write_drop", cache_write, 0);
        check("rst_valid_drop", rsp_valid, 0);
        sb.delete();
        @(negedge clock);
        reset_n = 1'b1;
        stub = 1'b0;
        issue(1'b1, 8'h50, 32'h5A5A0050);
        wait_done();
        check("post_rst_write", last_hit, 1);
        issue(1'b0, 8'h50, 32'h0);
        wait_done();
        check("post_rst_read", last_data, 32'h5A5A0050);

        // randomized traffic with random backpressure
        rdy_mode = 0;
        for (int i = 0; i < 40; i++) begin
            logic          w;
            logic [AW-1:0] a;
            w = 1'($urandom_range(0, 1));
            a = 8'h40 + 8'($urandom_range(0, 3)) * 8'h08;
            issue(w, a, $urandom);
        end
        wait_done();
        rdy_mode = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
